// File: rtl/adc_spi_capture.sv
// Self-timed capture front end for an AD7476-style serial ADC: frames CS_n/SCLK,
// shifts in one word per sample period and presents it as a held two's complement sample.
module adc_spi_capture #(
  parameter int ADC_MSB       = 11,
  parameter int LEAD_ZEROS    = 4,
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 200,
  parameter int OFFSET_BINARY = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adc_sdata,
  output logic           adc_cs_n,
  output logic           adc_sclk,
  output logic [ADC_MSB:0] ADC_bits,
  output logic           sample_valid,
  output logic           frame_err
);

  localparam int TOTAL_BITS  = LEAD_ZEROS + ADC_MSB + 1;
  localparam int CONV_CYCLES = CLK_DIV + 2 * CLK_DIV * TOTAL_BITS;
  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = $clog2(TOTAL_BITS + 1);

  localparam logic [PW-1:0] PCNT_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] PH_LOW_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] PH_HALF    = DW'(CLK_DIV);
  localparam logic [DW-1:0] PH_SLOT_END = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(TOTAL_BITS - 1);
  localparam logic [ADC_MSB:0] MSB_MASK = {1'b1, {ADC_MSB{1'b0}}};

  if (CLK_DIV < 1) begin : g_bad_div
    $error("adc_spi_capture: CLK_DIV must be at least 1");
  end
  if (SAMPLE_PERIOD < CONV_CYCLES + 2) begin : g_bad_period
    $error("adc_spi_capture: SAMPLE_PERIOD too short for one conversion");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Offset binary differs from two's complement only in the MSB.
  function automatic logic [ADC_MSB:0] code_to_sample(input logic [ADC_MSB:0] code);
    if (OFFSET_BINARY != 0) begin
      return code ^ MSB_MASK;
    end else begin
      return code;
    end
  endfunction

  state_t                state_q, state_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [DW-1:0]         ph_q, ph_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [TOTAL_BITS-1:0] shift_q, shift_d;
  logic [ADC_MSB:0]      bits_q, bits_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  // Next-state, shift and output-register computation
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (pcnt_q == '0) begin
          state_d = SETUP;
          ph_d    = '0;
          bit_d   = '0;
          shift_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (ph_q == PH_LOW_END) begin
          state_d = SHIFT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + DW'(1);
        end
      end
      SHIFT: begin
        // Sample on the edge that lifts SCLK, i.e. at the end of the low half.
        if (ph_q == PH_LOW_END) begin
          shift_d = {shift_q[TOTAL_BITS-2:0], adc_sdata};
        end else begin
          shift_d = shift_q;
        end
        if (ph_q == PH_SLOT_END) begin
          ph_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
            bits_d  = code_to_sample(shift_q[ADC_MSB:0]);
            valid_d = 1'b1;
            err_d   = (shift_q >> (ADC_MSB + 1)) != '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          ph_d = ph_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    sclk_d = !((state_d == SHIFT) && (ph_d < PH_HALF));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bits_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign ADC_bits     = bits_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture: an ADC model serves framed words, expected samples
// are queued per conversion and a monitor checks timing, data, flags and hold behaviour.
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_sdata = 1'b0;
  logic        cs0, sclk0, sv0, fe0, cs1, sclk1, sv1, fe1;
  logic [11:0] bits0, bits1;

  always #5 clk = ~clk;

  adc_spi_capture dut0 (
    .clk(clk), .rst(rst), .adc_sdata(adc_sdata), .adc_cs_n(cs0), .adc_sclk(sclk0),
    .ADC_bits(bits0), .sample_valid(sv0), .frame_err(fe0)
  );

  adc_spi_capture #(.OFFSET_BINARY(0)) dut1 (
    .clk(clk), .rst(rst), .adc_sdata(adc_sdata), .adc_cs_n(cs1), .adc_sclk(sclk1),
    .ADC_bits(bits1), .sample_valid(sv1), .frame_err(fe1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [11:0] bits;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] stim_q[$];

  // Offset binary code c represents the value c - 2048.
  function automatic logic [11:0] ob_to_tc(input logic [11:0] code);
    int v;
    v = int'(code) - 2048;
    return v[11:0];
  endfunction

  function automatic logic [15:0] rand_frame();
    logic [3:0] lead;
    lead = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    return {lead, 12'($urandom)};
  endfunction

  logic        started = 1'b0;
  logic        aborted = 1'b0;

  // ADC model: new frame on CS_n fall, next bit after each SCLK rise
  logic        m_cs_prev = 1'b1;
  logic        m_sclk_prev = 1'b1;
  int          idx = 0;
  logic [15:0] frame = 16'h0000;
  always @(negedge clk) begin
    if (started) begin
      if (cs0 === 1'b1) begin
        idx = 0;
      end else if (m_cs_prev === 1'b1) begin
        frame = (stim_q.size() > 0) ? stim_q.pop_front() : rand_frame();
        idx = 0;
        q0.push_back('{bits: ob_to_tc(frame[11:0]), err: (frame[15:12] != 4'h0)});
        q1.push_back('{bits: frame[11:0], err: (frame[15:12] != 4'h0)});
      end else if (sclk0 === 1'b1 && m_sclk_prev === 1'b0) begin
        idx++;
      end
      adc_sdata = (cs0 === 1'b0 && idx < 16) ? frame[15-idx] : 1'b0;
      m_cs_prev = cs0;
      m_sclk_prev = sclk0;
    end
  end

  // Monitor: frame timing, scoreboard pops and periodic filter reads
  int          cyc = 0;
  int          low_cnt = 0;
  int          rises = 0;
  int          last_fall = -1;
  int          nvalid = 0;
  logic        mon_cs_prev = 1'b1;
  logic        mon_sclk_prev = 1'b1;
  logic        mon_sv_prev = 1'b0;
  logic [11:0] last0 = 12'h000;
  logic [11:0] last1 = 12'h000;
  exp_t        e;
  always @(negedge clk) begin
    cyc++;
    if (started) begin
      if (cs0 === 1'b0) begin
        low_cnt++;
        if (sclk0 === 1'b1 && mon_sclk_prev === 1'b0) rises++;
      end
      if (cs0 === 1'b0 && mon_cs_prev === 1'b1) begin
        if (last_fall >= 0) check("cs_fall_period", cyc - last_fall, 200);
        last_fall = cyc;
      end
      if (cs0 === 1'b1 && mon_cs_prev === 1'b0) begin
        if (!aborted) begin
          check("cs_low_cycles", low_cnt, 66);
          check("sclk_rises", rises, 16);
          check("valid_at_cs_rise", sv0, 1);
        end
        low_cnt = 0;
        rises = 0;
        aborted = 1'b0;
      end
      if (sv0 === 1'b1) begin
        nvalid++;
        check("valid_single_cycle", mon_sv_prev, 0);
        if (q0.size() == 0) begin
          check("unexpected_valid0", 1, 0);
        end else begin
          e = q0.pop_front();
          check("adc_bits_ob", bits0, e.bits);
          check("frame_err_ob", fe0, e.err);
          last0 = e.bits;
        end
      end else if (fe0 !== 1'b0) begin
        check("frame_err_without_valid0", fe0, 0);
      end
      if (sv1 === 1'b1) begin
        if (q1.size() == 0) begin
          check("unexpected_valid1", 1, 0);
        end else begin
          e = q1.pop_front();
          check("adc_bits_raw", bits1, e.bits);
          check("frame_err_raw", fe1, e.err);
          last1 = e.bits;
        end
      end
      if (cyc % 40 == 0) begin
        check("filter_read_ob", bits0, last0);
        check("filter_read_raw", bits1, last1);
      end
      mon_cs_prev = cs0;
      mon_sclk_prev = sclk0;
      mon_sv_prev = sv0;
    end
  end

  int nv_start;
  int k;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs_n", cs0, 1);
    check("reset_sclk", sclk0, 1);
    check("reset_bits", bits0, 0);
    check("reset_valid", sv0, 0);
    check("reset_frame_err", fe0, 0);

    stim_q.push_back(16'h0800);
    stim_q.push_back(16'h0FFF);
    stim_q.push_back(16'h0000);
    stim_q.push_back(16'h4ABC);
    stim_q.push_back(16'h09A5);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    repeat (1000) @(negedge clk);
    check("phase1_valids", nvalid, 5);

    k = 0;
    while (cs0 !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
    check("mid_conv_cs_low", cs0, 0);

    aborted = 1'b1;
    last_fall = -1;
    q0.delete();
    q1.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_cs_n", cs0, 1);
    check("midrst_sclk", sclk0, 1);
    check("midrst_bits", bits0, 0);
    check("midrst_bits_raw", bits1, 0);
    check("midrst_valid", sv0, 0);
    last0 = 12'h000;
    last1 = 12'h000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nv_start = nvalid;
    stim_q.push_back(16'h09A5);
    stim_q.push_back(16'hF123);
    stim_q.push_back(16'h1800);
    repeat (2000) @(negedge clk);
    check("phase2_valids", nvalid - nv_start, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
